// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, a 2-entry skid buffer, flush and NOP
// control insertion whenever the stage holds no valid word.
module pipe_stage_skid #(
  parameter int unsigned            PC_W     = 32,
  parameter logic [PC_W-1:0]        PC_RST   = PC_W'(32'h0040_0000),
  parameter int unsigned            DATA_W   = 128,
  parameter int unsigned            CTRL_W   = 16,
  parameter logic [CTRL_W-1:0]      NOP_CTRL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e              state_q, state_d;
  logic                in_ready_q;
  logic [PC_W-1:0]     main_pc_q, skid_pc_q;
  logic [DATA_W-1:0]   main_data_q, skid_data_q;
  logic [CTRL_W-1:0]   main_ctrl_q, skid_ctrl_q;

  logic accept, pop;
  logic load_main_in, load_main_skid, load_skid, force_nop;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    force_nop      = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_d      = StOne;
        end
      end
      StOne: begin
        if (accept && pop) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = StFull;
        end else if (pop) begin
          force_nop = 1'b1;
          state_d   = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          load_main_skid = 1'b1;
          state_d        = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush drops the incoming word and both entries; pc/data keep their last value.
    if (flush) begin
      state_d        = StEmpty;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      force_nop      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      main_pc_q   <= PC_RST;
      main_data_q <= '0;
      main_ctrl_q <= NOP_CTRL;
      skid_pc_q   <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= NOP_CTRL;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StFull);
      if (load_main_in) begin
        main_pc_q   <= in_pc;
        main_data_q <= in_data;
        main_ctrl_q <= in_ctrl;
      end else if (load_main_skid) begin
        main_pc_q   <= skid_pc_q;
        main_data_q <= skid_data_q;
        main_ctrl_q <= skid_ctrl_q;
      end else if (force_nop) begin
        main_ctrl_q <= NOP_CTRL;
      end
      if (load_skid) begin
        skid_pc_q   <= in_pc;
        skid_data_q <= in_data;
        skid_ctrl_q <= in_ctrl;
      end
    end
  end

  always_comb begin
    occupancy = 2'd0;
    unique case (state_q)
      StEmpty: occupancy = 2'd0;
      StOne:   occupancy = 2'd1;
      StFull:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != StEmpty);
  assign out_pc    = main_pc_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;

endmodule
